ram_initiator: RTL
==================

# ram_initiator

Initiator-side controller for the single-port 256 x 64 synchronous RAM: the one block that drives the RAM's cen/wen/addr/din pins and captures its dout. It turns one command (single read, single write, burst read, burst fill) into correctly timed RAM cycles and returns read data on a valid-only response stream. It sits between the factorial datapath/sequencer and the RAM, so no other block drives RAM pins directly.

## Interface
Parameters: none. Fixed 8-bit address and 64-bit data, matching the RAM.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge with cmd_valid && cmd_ready.
- cmd_op  in  2  operation code: 00 single read, 01 single write, 10 burst read, 11 burst fill.
- cmd_addr  in  8  start address.
- cmd_len  in  8  burst length minus 1 (0..255 gives 1..256 words). Ignored for single ops.
- cmd_wdata  in  64  write/fill data, captured at accept.
- rsp_valid  out  1  one-cycle read-data strobe. No backpressure.
- rsp_data  out  64  read word; holds its last value when rsp_valid is low.
- rsp_last  out  1  high with the final rsp_valid of a read command.
- done  out  1  one-cycle pulse when a command completes.
- m_cen  out  1  RAM chip enable.
- m_wen  out  1  RAM write enable.
- m_addr  out  8  RAM address.
- m_din  out  64  RAM write data.
- m_dout  in  64  RAM read data; the RAM registers it at the edge that samples a read.

## Operation
- States: IDLE, RD, WR, DRAIN.
- Accept from IDLE:
  - ops 00/10 go to RD; ops 01/11 go to WR.
  - Captured: address counter = cmd_addr, remaining = cmd_len (0 for single ops), data = cmd_wdata.
- RD: drives m_cen=1, m_wen=0, m_addr=counter for one cycle per word.
  - Counter increments and wraps 8'hFF to 8'h00.
  - After the last word is issued, go to DRAIN.
- WR: drives m_cen=1, m_wen=1, m_addr=counter, m_din=data for one cycle per word.
  - After the last word: go to IDLE and pulse done.
- DRAIN: m_cen=0. Wait until the 2-stage response tracker is empty, then go to IDLE.
- Response tracker: a 2-stage shift of {valid, last} per issued read.
  - rsp_data <= m_dout when stage 2 is valid.
  - done is asserted together with rsp_last.
- Idle pins: m_cen=0, m_wen=0. m_addr and m_din hold their last values.
- No new command is accepted until the previous one has fully completed, including the read drain, so reads and writes never overlap.
- A burst of 256 words starting at any address touches every location exactly once.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_last=0, done=0, m_cen=0, m_wen=0, m_addr=0, m_din=0, rsp_data=0, state IDLE.
- Reset assertion drops m_cen asynchronously. A burst interrupted by reset performs no further RAM writes, and in-flight reads are discarded (no rsp_valid).
- Let E0 be the accept edge.
- Reads: word k is driven on the RAM pins in the cycle after edge E0+k. The RAM samples it at E0+k+1. rsp_valid for word k is high in the cycle after E0+k+2.
  - Single read: rsp_valid, rsp_last, done and cmd_ready are all high in the cycle after E2.
- Writes: word k is written at E0+k+1. done and cmd_ready are high in the cycle after E0+len+1.
  - Single write: done is high in the cycle after E0+1.
- Throughput: one word per cycle, with no bubbles inside a burst.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold it.
- A new command may be accepted on the same edge where done is high.

## Configuration
- RAM_INIT_BURST_EN defined: ops 10/11 perform bursts as above.
- Undefined: cmd_len is ignored (treated as 0), op 10 behaves as a single read, op 11 as a single write, and the length counter logic is removed.

## Test plan
- Single write 64'h0000_0000_0000_0078 to 8'h05, then single read of 8'h05: rsp_data=64'h78 with rsp_valid/rsp_last/done in the cycle after E2. The RAM never sees cen=1 in the cycle between the two commands.
- Burst fill, addr 8'hFE, len 3, data 64'hA5: writes land in FE, FF, 00, 01. A burst read of FD..02 returns 0, A5, A5, A5, A5, 0 on 6 consecutive cycles, with rsp_last only on the 6th.
- Burst read, len 255, from 8'h80: 256 back-to-back rsp_valid, exactly one done, and cmd_ready low throughout until done.
- Hold cmd_valid during a burst: the command is accepted only on the done edge, and the next first read is issued the cycle after.
- Assert reset_n low mid burst fill (word 2 of 8): m_cen falls immediately, no later addresses are modified, and all outputs take their reset values.
- With RAM_INIT_BURST_EN undefined, op 11 with len 7 at 8'h10: only 8'h10 is written, and done follows 1 cycle after the write edge.

Source files
------------

// File: rtl/ram_initiator_if.sv
// ---------------------------------------------------------------------------
// ram_initiator_if
//
// Purpose : Bundles the command stream, the valid-only read-response stream
//           and the single-port 256 x 64 RAM pins of the RAM initiator.
//
// Signals :
//   cmd_valid / cmd_ready   command handshake (accept on valid && ready)
//   cmd_op[1:0]             00 single read, 01 single write,
//                           10 burst read,  11 burst fill
//   cmd_addr[7:0]           start address
//   cmd_len[7:0]            burst length minus 1
//   cmd_wdata[63:0]         write / fill data
//   rsp_valid / rsp_data    one-cycle read-data strobe and data (no backpressure)
//   rsp_last                final response word of a read command
//   done                    one-cycle completion pulse
//   m_cen / m_wen           RAM chip enable / write enable
//   m_addr[7:0]             RAM address
//   m_din[63:0]             RAM write data
//   m_dout[63:0]            RAM registered read data
//
// Modports:
//   master : the environment around the initiator (requester plus the RAM
//            macro). It drives commands and m_dout, and observes everything else.
//   slave  : the ram_initiator itself.
// ---------------------------------------------------------------------------
interface ram_initiator_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic [63:0] cmd_wdata;

   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        rsp_last;
   logic        done;

   logic        m_cen;
   logic        m_wen;
   logic [7:0]  m_addr;
   logic [63:0] m_din;
   logic [63:0] m_dout;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata, m_dout,
      input  cmd_ready, rsp_valid, rsp_data, rsp_last, done,
             m_cen, m_wen, m_addr, m_din
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata, m_dout,
      output cmd_ready, rsp_valid, rsp_data, rsp_last, done,
             m_cen, m_wen, m_addr, m_din
   );
endinterface

// File: rtl/ram_initiator.sv
// ---------------------------------------------------------------------------
// ram_initiator
//
// Purpose : Sole driver of the 256 x 64 single-port synchronous RAM. Turns one
//           command (single read, single write, burst read, burst fill) into
//           back-to-back RAM cycles and returns read data on a valid-only
//           response stream. Commands are fully serialised: a new command is
//           only accepted once the previous one, including its read drain,
//           has completed.
//
// Ports   :
//   clk      in   rising-edge clock shared with the RAM
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of ram_initiator_if (command, response, RAM pins)
//
// Build option:
//   RAM_INIT_BURST_EN  defined   -> ops 10/11 run cmd_len+1 words
//                      undefined -> cmd_len ignored, ops 10/11 behave as
//                                   single read / single write and the
//                                   length counter is not built
//
// Timing summary (E0 = accept edge):
//   word k is on the RAM pins in the cycle after E0+k; the RAM registers read
//   data at E0+k+1; rsp_valid for word k is high in the cycle after E0+k+2.
//   A write command's done pulse is in the cycle after E0+len+1.
// ---------------------------------------------------------------------------
module ram_initiator (
   input  logic           clk,
   input  logic           reset_n,
   ram_initiator_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_WR    = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_addr;       // address counter, doubles as the m_addr pin
   logic [63:0] r_data;       // captured write data, doubles as the m_din pin

   // Response tracker: stage 1 follows the RAM sampling edge, stage 2 is the
   // response strobe itself.
   logic        r_s1_valid;
   logic        r_s1_last;
   logic        r_rsp_valid;
   logic        r_rsp_last;
   logic [63:0] r_rsp_data;
   logic        r_wr_done;

   logic        w_accept;
   logic        w_issue;
   logic        w_rd_issue;
   logic        w_wr_issue;
   logic        w_last_word;

   assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
   assign w_rd_issue = (r_state == S_RD);
   assign w_wr_issue = (r_state == S_WR);
   assign w_issue    = w_rd_issue || w_wr_issue;

`ifdef RAM_INIT_BURST_EN
   // Words still to issue after the current one. Single ops load zero.
   logic [7:0] r_remain;

   assign w_last_word = (r_remain == 8'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_remain <= 8'd0;
      end else if (w_accept) begin
         r_remain <= bus.cmd_op[1] ? bus.cmd_len : 8'd0;
      end else if (w_issue && !w_last_word) begin
         r_remain <= r_remain - 8'd1;
      end
   end
`else
   // Every command is a single word; length and burst bit are not needed.
   logic w_unused_cmd;

   assign w_last_word  = 1'b1;
   assign w_unused_cmd = ^{bus.cmd_len, bus.cmd_op[1]};
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = bus.cmd_op[0] ? S_WR : S_RD;
            end
         end
         S_RD: begin
            if (w_last_word) begin
               w_state_next = S_DRAIN;
            end
         end
         S_WR: begin
            if (w_last_word) begin
               w_state_next = S_IDLE;
            end
         end
         S_DRAIN: begin
            // Stage 1 holding the last read means the RAM has already
            // returned its data; the final strobe comes out of stage 2 in
            // the first IDLE cycle, so the next command cannot collide.
            if (!r_s1_valid || r_s1_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Address / data capture. The counter only advances while more words
   // follow, so after a command m_addr keeps showing the last address used.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= 8'd0;
         r_data <= 64'd0;
      end else if (w_accept) begin
         r_addr <= bus.cmd_addr;
         r_data <= bus.cmd_wdata;
      end else if (w_issue && !w_last_word) begin
         r_addr <= r_addr + 8'd1;   // wraps FF -> 00
      end
   end

   // ------------------------------------------------------------------
   // Read response tracker and write completion
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_data  <= 64'd0;
         r_wr_done   <= 1'b0;
      end else begin
         r_s1_valid  <= w_rd_issue;
         r_s1_last   <= w_rd_issue && w_last_word;
         r_rsp_valid <= r_s1_valid;
         r_rsp_last  <= r_s1_valid && r_s1_last;
         // m_dout carries the word sampled one edge earlier, i.e. the word
         // now moving from stage 1 into stage 2.
         if (r_s1_valid) begin
            r_rsp_data <= bus.m_dout;
         end
         r_wr_done   <= w_wr_issue && w_last_word;
      end
   end

   // ------------------------------------------------------------------
   // FSM: outputs. m_cen decodes straight from the state so that reset
   // removes it without waiting for a clock.
   // ------------------------------------------------------------------
   always_comb begin
      bus.cmd_ready = (r_state == S_IDLE);
      bus.m_cen     = w_issue;
      bus.m_wen     = w_wr_issue;
      bus.m_addr    = r_addr;
      bus.m_din     = r_data;
      bus.rsp_valid = r_rsp_valid;
      bus.rsp_last  = r_rsp_last;
      bus.rsp_data  = r_rsp_data;
      bus.done      = r_rsp_last | r_wr_done;
   end

endmodule
